op_ctrl_vars_gen: RTL and testbench



---
 rtl/op_ctrl_vars_gen.sv | 112 +++++++++++
 tb/tb_op_ctrl_vars_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/op_ctrl_vars_gen.sv
// Three-deep loop-nest iteration generator: after a flush it issues one en pulse per
// iteration point every II cycles with the point's indices on ctrl_vars, then raises done.
module op_ctrl_vars_gen #(
  parameter logic [15:0] EXTENT_0 = 16'd1,
  parameter logic [15:0] EXTENT_1 = 16'd62,
  parameter logic [15:0] EXTENT_2 = 16'd62,
  parameter logic [15:0] START    = 16'd0,
  parameter logic [15:0] II       = 16'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall,
  output logic             en,
  output logic [2:0][15:0] ctrl_vars,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] E0_M1    = EXTENT_0 - 16'd1;
  localparam logic [15:0] E1_M1    = EXTENT_1 - 16'd1;
  localparam logic [15:0] E2_M1    = EXTENT_2 - 16'd1;
  localparam logic [15:0] START_M1 = START - 16'd1;
  localparam logic [15:0] II_M1    = II - 16'd1;

  // An empty nest skips straight to DONE at the point the first en would have appeared.
  localparam logic       ZERO_EXT  = (EXTENT_0 == 16'd0) || (EXTENT_1 == 16'd0) ||
                                     (EXTENT_2 == 16'd0);
  localparam logic [1:0] S_ISSUE   = ZERO_EXT ? S_DONE : S_RUN;
  localparam logic [1:0] S_RESTART = (START != 16'd0) ? S_DELAY : S_ISSUE;

  logic [1:0]       state_q, state_d;
  logic [15:0]      dly_q, dly_d;
  logic [15:0]      phase_q, phase_d;
  logic [2:0][15:0] idx_q, idx_d;
  logic             issue;
  logic             last_pt;

  assign issue   = (state_q == S_RUN) && (phase_q == 16'd0) && !stall;
  assign last_pt = (idx_q[0] == E0_M1) && (idx_q[1] == E1_M1) && (idx_q[2] == E2_M1);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = S_RESTART;
      dly_d   = 16'd0;
      phase_d = 16'd0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (!stall) begin
            if (dly_q == START_M1) begin
              state_d = S_ISSUE;
              dly_d   = 16'd0;
            end else begin
              dly_d = dly_q + 16'd1;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            phase_d = (phase_q == II_M1) ? 16'd0 : phase_q + 16'd1;
          end
          // Indices freeze on the final point so DONE keeps showing it.
          if (issue) begin
            if (last_pt) begin
              state_d = S_DONE;
            end else if (idx_q[2] != E2_M1) begin
              idx_d[2] = idx_q[2] + 16'd1;
            end else begin
              idx_d[2] = 16'd0;
              if (idx_q[1] != E1_M1) begin
                idx_d[1] = idx_q[1] + 16'd1;
              end else begin
                idx_d[1] = 16'd0;
                idx_d[0] = idx_q[0] + 16'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dly_q   <= 16'd0;
      phase_q <= 16'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign en        = issue;
  assign ctrl_vars = idx_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_op_ctrl_vars_gen.sv
module tb_op_ctrl_vars_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic fl0, st0, fl1, st1, fl2, st2;
  logic en0, en1, en2, done0, done1, done2;
  logic [2:0][15:0] cv0, cv1, cv2;

  int checks = 0;
  int failures = 0;

  op_ctrl_vars_gen #(.START(16'd5)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0), .stall(st0),
    .en(en0), .ctrl_vars(cv0), .done(done0));

  op_ctrl_vars_gen #(.EXTENT_0(16'd1), .EXTENT_1(16'd2), .EXTENT_2(16'd3),
                     .START(16'd0), .II(16'd3)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1), .stall(st1),
    .en(en1), .ctrl_vars(cv1), .done(done1));

  op_ctrl_vars_gen #(.EXTENT_1(16'd0), .START(16'd2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(fl2), .stall(st2),
    .en(en2), .ctrl_vars(cv2), .done(done2));

  function automatic logic [47:0] mk(input int o, input int m, input int i);
    logic [15:0] a, b, c;
    a = o[15:0];
    b = m[15:0];
    c = i[15:0];
    return {c, b, a};
  endfunction

  // Indices of the n-th point (0-based) of the default 1x62x62 nest.
  function automatic logic [47:0] mk_def(input int n);
    return mk(n / 3844, (n / 62) % 62, n % 62);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flush u0 and watch a full schedule, optionally stalling cycles slo..shi after the flush.
  task automatic run_u0(input int ncyc, input int slo, input int shi,
                        output int n_en, output int first_k, output int last_k,
                        output int done_k);
    n_en = 0; first_k = -1; last_k = -1; done_k = -1;
    @(posedge clk); #1 fl0 = 1'b1; st0 = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1 fl0 = 1'b0; st0 = (k >= slo && k <= shi);
      #1;
      if (st0) begin
        chk("stall_en", {63'd0, en0}, 64'd0);
        chk("stall_hold", {16'd0, cv0}, {16'd0, mk_def(n_en)});
      end
      if (en0) begin
        chk("run_idx", {16'd0, cv0}, {16'd0, mk_def(n_en)});
        if (first_k < 0) first_k = k;
        last_k = k;
        n_en++;
      end
      if (done0 && done_k < 0) done_k = k;
    end
    st0 = 1'b0;
  endtask

  int n_en, first_k, last_k, done_k, n1;

  initial begin
    rst_n = 1'b0;
    fl0 = 1'b0; st0 = 1'b0; fl1 = 1'b0; st1 = 1'b0; fl2 = 1'b0; st2 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_en", {63'd0, en0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_cv", {16'd0, cv0}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("idle_en", {63'd0, en0}, 64'd0);
    chk("idle_done", {63'd0, done0}, 64'd0);

    // Full default schedule, START=5.
    run_u0(3860, -1, -1, n_en, first_k, last_k, done_k);
    chk("full_count", n_en, 3844);
    chk("full_first", first_k, 6);
    chk("full_last", last_k, 3849);
    chk("full_done", done_k, 3850);
    chk("done_cv", {16'd0, cv0}, {16'd0, mk(0, 61, 61)});
    chk("done_en", {63'd0, en0}, 64'd0);

    // Stall for three cycles of RUN; everything after slips by three.
    run_u0(3860, 10, 12, n_en, first_k, last_k, done_k);
    chk("stall_count", n_en, 3844);
    chk("stall_first", first_k, 6);
    chk("stall_last", last_k, 3852);
    chk("stall_done", done_k, 3853);

    // Mid-RUN flush while {0,5,7} is being issued.
    @(posedge clk); #1 fl0 = 1'b1;
    for (int k = 1; k <= 323; k++) begin
      @(posedge clk); #1 fl0 = (k == 323);
      #1;
    end
    chk("mid_cv", {16'd0, cv0}, {16'd0, mk(0, 5, 7)});
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1 fl0 = 1'b0;
      #1;
      chk("mid_en", {63'd0, en0}, {63'd0, (j == 6)});
      chk("mid_done", {63'd0, done0}, 64'd0);
      if (j == 6) chk("mid_cv0", {16'd0, cv0}, 64'd0);
    end

    // Flush together with stall mid-RUN.
    repeat (14) @(posedge clk);
    #1 fl0 = 1'b1; st0 = 1'b1;
    #1 chk("fs_pre_en", {63'd0, en0}, 64'd0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1 fl0 = 1'b0; st0 = 1'b0;
      #1;
      chk("fs_en", {63'd0, en0}, {63'd0, (j == 6)});
      if (j == 6) chk("fs_cv", {16'd0, cv0}, 64'd0);
    end

    // Asynchronous reset in the middle of RUN.
    repeat (4) @(posedge clk);
    #2 chk("rr_pre_en", {63'd0, en0}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_en", {63'd0, en0}, 64'd0);
    chk("rr_cv", {16'd0, cv0}, 64'd0);
    chk("rr_done", {63'd0, done0}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #2;
      chk("rr_quiet", {63'd0, en0}, 64'd0);
    end

    // EXTENT={1,2,3}, II=3, START=0.
    @(posedge clk); #1 fl1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1 fl1 = 1'b0;
      #1;
      chk("ii_en", {63'd0, en1}, {63'd0, (k % 3 == 1 && k <= 16)});
      if (en1) begin
        n1 = (k - 1) / 3;
        chk("ii_cv", {16'd0, cv1}, {16'd0, mk(0, n1 / 3, n1 % 3)});
      end
      chk("ii_done", {63'd0, done1}, {63'd0, (k >= 17)});
    end

    // Empty middle loop, START=2.
    @(posedge clk); #1 fl2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1 fl2 = 1'b0;
      #1;
      chk("zero_en", {63'd0, en2}, 64'd0);
      chk("zero_done", {63'd0, done2}, {63'd0, (k >= 3)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
